// File: rtl/tetris_pkg.sv
// Shared types for the MOVE-phase scheduler: move opcodes and scheduler FSM states.
package tetris_pkg;

  typedef enum logic [1:0] {
    OP_DOWN  = 2'd0,
    OP_LEFT  = 2'd1,
    OP_RIGHT = 2'd2,
    OP_ROT   = 2'd3
  } mv_op_t;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_LOCK    = 3'd2,
    S_CONFIRM = 3'd3,
    S_DONE    = 3'd4
  } sched_state_t;

endpackage

// File: rtl/gravity_timer.sv
// Level-dependent gravity period with a down-counter; tick pulses once per period while run=1.
module gravity_timer #(
  parameter int unsigned GRAV_W      = 24,
  parameter int unsigned GRAV_PERIOD = 5_000_000,
  parameter int unsigned LEVEL_STEP  = 300_000,
  parameter int unsigned MIN_PERIOD  = 500_000
) (
  input  logic       clka,
  input  logic       restart_n,
  input  logic       run,
  input  logic [3:0] level,
  output logic       tick
);

  localparam int unsigned WW = GRAV_W + 4;
  // Reset uses the level-0 period; the counter is reloaded on every run rising edge anyway.
  localparam logic [GRAV_W-1:0] RST_PERIOD =
    GRAV_W'((GRAV_PERIOD < MIN_PERIOD) ? MIN_PERIOD : GRAV_PERIOD);

  logic [WW-1:0]     base;
  logic [WW-1:0]     floor_p;
  logic [WW-1:0]     step;
  logic [WW-1:0]     diff;
  logic [GRAV_W-1:0] period;
  logic [GRAV_W-1:0] cnt;
  logic              run_q;

  always_comb begin
    base    = WW'(GRAV_PERIOD);
    floor_p = WW'(MIN_PERIOD);
    step    = WW'(level) * WW'(LEVEL_STEP);
    diff    = base - step;
    if ((step > base) || (diff < floor_p)) begin
      period = floor_p[GRAV_W-1:0];
    end else begin
      period = diff[GRAV_W-1:0];
    end
  end

  // Ticking on the last count (1) rather than after reaching 0 keeps the interval exactly P cycles.
  assign tick = run && run_q && (cnt <= GRAV_W'(1));

  always_ff @(posedge clka or negedge restart_n) begin
    if (!restart_n) begin
      cnt   <= RST_PERIOD;
      run_q <= 1'b0;
    end else begin
      run_q <= run;
      if (run) begin
        if (!run_q || (cnt <= GRAV_W'(1))) begin
          cnt <= period;
        end else begin
          cnt <= cnt - GRAV_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/move_scheduler.sv
// MOVE-phase sequencer: arbitrates button/gravity requests into single req/ack moves, runs lock delay.
module move_scheduler
  import tetris_pkg::*;
#(
  parameter int unsigned GRAV_W      = 24,
  parameter int unsigned GRAV_PERIOD = 5_000_000,
  parameter int unsigned LEVEL_STEP  = 300_000,
  parameter int unsigned MIN_PERIOD  = 500_000,
  parameter int unsigned LOCK_CYC    = 1_000_000
) (
  input  logic       clka,
  input  logic       restart_n,
  input  logic       start_move,
  input  logic [3:0] level,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_rot,
  input  logic       btn_drop,
  output logic       mv_req,
  output mv_op_t     mv_op,
  input  logic       mv_ack,
  input  logic       mv_blocked,
  output logic       touched,
  output logic       busy
);

  localparam int unsigned LOCK_W = $clog2(LOCK_CYC + 2);

  sched_state_t      state;
  logic              grav_tick;
  logic              grav_pend, drop_pend, rot_pend, left_pend, right_pend;
  logic              from_lock;
  logic [LOCK_W-1:0] lock_cnt;
  logic              any_pend;
  mv_op_t            win_op;
  logic              ack_fire;
  logic              flush;
  logic              clr_down, clr_rot, clr_left, clr_right;

  gravity_timer #(
    .GRAV_W      (GRAV_W),
    .GRAV_PERIOD (GRAV_PERIOD),
    .LEVEL_STEP  (LEVEL_STEP),
    .MIN_PERIOD  (MIN_PERIOD)
  ) u_gravity (
    .clka      (clka),
    .restart_n (restart_n),
    .run       (start_move),
    .level     (level),
    .tick      (grav_tick)
  );

  always_comb begin
    any_pend = grav_pend | drop_pend | rot_pend | left_pend | right_pend;
    win_op   = OP_DOWN;
    if (grav_pend || drop_pend) win_op = OP_DOWN;
    else if (rot_pend)          win_op = OP_ROT;
    else if (left_pend)         win_op = OP_LEFT;
    else if (right_pend)        win_op = OP_RIGHT;
    ack_fire  = mv_req && mv_ack;
    clr_down  = ack_fire && (mv_op == OP_DOWN);
    clr_rot   = ack_fire && (mv_op == OP_ROT);
    clr_left  = ack_fire && (mv_op == OP_LEFT);
    clr_right = ack_fire && (mv_op == OP_RIGHT);
    flush     = !start_move && (state == S_IDLE);
  end

  assign busy = (state != S_IDLE);

  // Clear-on-ack is applied before OR-ing in new pulses so a same-cycle pulse re-arms the flag.
  always_ff @(posedge clka or negedge restart_n) begin
    if (!restart_n) begin
      grav_pend  <= 1'b0;
      drop_pend  <= 1'b0;
      rot_pend   <= 1'b0;
      left_pend  <= 1'b0;
      right_pend <= 1'b0;
    end else if (flush) begin
      grav_pend  <= 1'b0;
      drop_pend  <= 1'b0;
      rot_pend   <= 1'b0;
      left_pend  <= 1'b0;
      right_pend <= 1'b0;
    end else begin
      grav_pend  <= (grav_pend  & ~clr_down)  | grav_tick;
      drop_pend  <= (drop_pend  & ~clr_down)  | btn_drop;
      rot_pend   <= (rot_pend   & ~clr_rot)   | btn_rot;
      left_pend  <= (left_pend  & ~clr_left)  | btn_left;
      right_pend <= (right_pend & ~clr_right) | btn_right;
    end
  end

  always_ff @(posedge clka or negedge restart_n) begin
    if (!restart_n) begin
      state     <= S_IDLE;
      mv_req    <= 1'b0;
      mv_op     <= OP_DOWN;
      touched   <= 1'b0;
      from_lock <= 1'b0;
      lock_cnt  <= '0;
    end else begin
      touched <= 1'b0;
      // Lock delay keeps running while a lateral/rotate move is serviced out of LOCK.
      if (((state == S_LOCK) || ((state == S_ISSUE) && from_lock)) && (lock_cnt != '0)) begin
        lock_cnt <= lock_cnt - LOCK_W'(1);
      end
      case (state)
        S_IDLE: begin
          from_lock <= 1'b0;
          if (start_move && any_pend) begin
            state  <= S_ISSUE;
            mv_req <= 1'b1;
            mv_op  <= win_op;
          end
        end
        S_ISSUE: begin
          if (mv_ack) begin
            mv_req <= 1'b0;
            if (!start_move) begin
              state <= S_IDLE;
            end else if (mv_op == OP_DOWN) begin
              if (mv_blocked) begin
                state <= S_LOCK;
                if (!from_lock) lock_cnt <= LOCK_W'(LOCK_CYC);
              end else begin
                state <= S_IDLE;
              end
            end else begin
              state <= from_lock ? S_LOCK : S_IDLE;
            end
          end
        end
        S_LOCK: begin
          if (!start_move) begin
            state <= S_IDLE;
          end else if (lock_cnt <= LOCK_W'(1)) begin
            state  <= S_CONFIRM;
            mv_req <= 1'b1;
            mv_op  <= OP_DOWN;
          end else if (any_pend) begin
            state     <= S_ISSUE;
            from_lock <= 1'b1;
            mv_req    <= 1'b1;
            mv_op     <= win_op;
          end
        end
        S_CONFIRM: begin
          if (mv_ack) begin
            mv_req <= 1'b0;
            if (start_move && mv_blocked) begin
              state   <= S_DONE;
              touched <= 1'b1;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        S_DONE: begin
          if (!start_move) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_move_scheduler.sv
// Scoreboard bench for move_scheduler with small gravity/lock timing parameters.
module tb_move_scheduler;
  import tetris_pkg::*;

  localparam int unsigned T_GRAV_PERIOD = 8;
  localparam int unsigned T_LEVEL_STEP  = 2;
  localparam int unsigned T_MIN_PERIOD  = 2;
  localparam int unsigned T_LOCK_CYC    = 3;

  logic       clka = 1'b0;
  logic       restart_n = 1'b0;
  logic       start_move = 1'b0;
  logic [3:0] level = 4'd0;
  logic       btn_left = 1'b0, btn_right = 1'b0, btn_rot = 1'b0, btn_drop = 1'b0;
  logic       mv_req;
  logic [1:0] mv_op;
  logic       mv_ack = 1'b0, mv_blocked = 1'b0;
  logic       touched;
  logic       busy;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0] op;
    int         at;
    int         delay;
    bit         blk;
  } exp_t;

  exp_t exp_q[$];
  int   touch_q[$];

  move_scheduler #(
    .GRAV_W      (24),
    .GRAV_PERIOD (T_GRAV_PERIOD),
    .LEVEL_STEP  (T_LEVEL_STEP),
    .MIN_PERIOD  (T_MIN_PERIOD),
    .LOCK_CYC    (T_LOCK_CYC)
  ) dut (
    .clka       (clka),
    .restart_n  (restart_n),
    .start_move (start_move),
    .level      (level),
    .btn_left   (btn_left),
    .btn_right  (btn_right),
    .btn_rot    (btn_rot),
    .btn_drop   (btn_drop),
    .mv_req     (mv_req),
    .mv_op      (mv_op),
    .mv_ack     (mv_ack),
    .mv_blocked (mv_blocked),
    .touched    (touched),
    .busy       (busy)
  );

  always #5 clka = ~clka;
  always @(posedge clka) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clka);
      #1;
    end
  endtask

  task automatic expect_req(input logic [1:0] op, input int at, input int delay, input bit blk);
    exp_t e;
    e.op = op; e.at = at; e.delay = delay; e.blk = blk;
    exp_q.push_back(e);
  endtask

  // First gravity request lands P+2 cycles after start_move is raised, then every P cycles.
  task automatic run_grav(input logic [3:0] lvl, input int p, input int n);
    int r;
    level      = lvl;
    start_move = 1'b1;
    r          = cyc;
    for (int k = 0; k < n; k++) expect_req(OP_DOWN, r + p + 2 + k * p, 0, 1'b0);
    step(p + 2 + (n - 1) * p + 1);
    start_move = 1'b0;
    step(3);
    check("grav_idle_busy", busy, 0);
  endtask

  // Monitor doubles as the datapath responder: acks after the queued delay with the queued result.
  initial begin : monitor
    exp_t cur;
    int   held;
    bit   in_txn;
    in_txn = 1'b0;
    held   = 0;
    cur    = '{OP_DOWN, 0, 0, 1'b0};
    forever begin
      @(negedge clka);
      mv_ack     = 1'b0;
      mv_blocked = 1'b0;
      if (in_txn) begin
        if (!mv_req) begin
          check("req_held", mv_req, 1);
          in_txn = 1'b0;
        end else begin
          check("op_stable", mv_op, cur.op);
        end
      end else if (mv_req) begin
        if (exp_q.size() == 0) begin
          check("unexpected_req", mv_req, 0);
          cur = '{mv_op, cyc, 0, 1'b0};
        end else begin
          cur = exp_q.pop_front();
          check("req_op", mv_op, cur.op);
          check("req_cycle", cyc, cur.at);
        end
        in_txn = 1'b1;
        held   = 0;
      end
      if (in_txn && mv_req) begin
        if (held == cur.delay) begin
          mv_ack     = 1'b1;
          mv_blocked = cur.blk;
          in_txn     = 1'b0;
        end else begin
          held++;
        end
      end
      if (touched) begin
        if (touch_q.size() == 0) check("unexpected_touched", touched, 0);
        else check("touched_cycle", cyc, touch_q.pop_front());
      end
    end
  end

  initial begin : watchdog
    #50000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin : driver
    int r;
    // Reset with button activity
    for (int i = 0; i < 6; i++) begin
      btn_left  = (i % 2 == 0);
      btn_rot   = (i % 3 == 0);
      btn_drop  = (i % 2 == 1);
      btn_right = (i == 4);
      step(1);
      check("rst_mv_req", mv_req, 0);
      check("rst_touched", touched, 0);
      check("rst_busy", busy, 0);
    end
    check("rst_mv_op", mv_op, int'(OP_DOWN));
    btn_left = 1'b0; btn_rot = 1'b0; btn_drop = 1'b0; btn_right = 1'b0;
    step(1);
    restart_n = 1'b1;
    step(2);
    check("post_rst_busy", busy, 0);

    // Gravity period vs level: P=8, P=2, floor (underflow), P=6
    run_grav(4'd0, 8, 3);
    run_grav(4'd3, 2, 3);
    run_grav(4'd15, 2, 3);
    run_grav(4'd1, 6, 2);

    // Priority: gravity tick together with rot and left
    level      = 4'd0;
    start_move = 1'b1;
    r          = cyc;
    expect_req(OP_DOWN,  r + 10, 0, 1'b0);
    expect_req(OP_ROT,   r + 12, 0, 1'b0);
    expect_req(OP_LEFT,  r + 14, 0, 1'b0);
    expect_req(OP_DOWN,  r + 18, 0, 1'b0);
    step(8);
    btn_left = 1'b1; btn_rot = 1'b1;
    step(1);
    btn_left = 1'b0; btn_rot = 1'b0;
    step(11);
    start_move = 1'b0;
    step(3);

    // Lock delay with a lateral move during lock; confirm blocked -> touched
    start_move = 1'b1;
    r          = cyc;
    expect_req(OP_DOWN,  r + 10, 0, 1'b1);
    expect_req(OP_RIGHT, r + 12, 0, 1'b0);
    expect_req(OP_DOWN,  r + 14, 0, 1'b1);
    touch_q.push_back(r + 15);
    step(10);
    btn_right = 1'b1;
    step(1);
    btn_right = 1'b0;
    step(2);
    check("lock_busy", busy, 1);
    step(3);
    check("done_touched_low", touched, 0);
    check("done_busy", busy, 1);
    start_move = 1'b0;
    step(2);
    check("after_done_busy", busy, 0);
    step(2);

    // Confirm succeeds -> no touched, gravity keeps its rhythm
    start_move = 1'b1;
    r          = cyc;
    expect_req(OP_DOWN, r + 10, 0, 1'b1);
    expect_req(OP_DOWN, r + 14, 0, 1'b0);
    expect_req(OP_DOWN, r + 18, 0, 1'b0);
    expect_req(OP_DOWN, r + 26, 0, 1'b0);
    step(27);
    start_move = 1'b0;
    step(3);
    check("slide_busy", busy, 0);

    // start_move falls mid-handshake; ack on the 5th cycle; result discarded, flags flushed
    start_move = 1'b1;
    r          = cyc;
    expect_req(OP_DOWN, r + 10, 4, 1'b1);
    step(10);
    start_move = 1'b0;
    btn_left   = 1'b1;
    step(1);
    btn_left = 1'b0;
    step(2);
    check("abort_req_held", mv_req, 1);
    step(3);
    check("abort_req_low", mv_req, 0);
    check("abort_busy", busy, 0);
    step(3);
    start_move = 1'b1;
    r          = cyc;
    expect_req(OP_DOWN, r + 10, 0, 1'b0);
    step(11);
    start_move = 1'b0;
    step(5);

    check("exp_queue_empty", exp_q.size(), 0);
    check("touch_queue_empty", touch_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
